// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys are expanded forward to rk10, then walked back.
//
// Ports:
//   Clk, Rst   clock and synchronous active-high reset
//   Start      request, sampled only in IDLE
//   Key_In     128-bit cipher key, bit 127 = key byte 0
//   Cipher_In  128-bit cipher text, bit 127 = byte 0
//   Busy       high while a block is in flight
//   Done       one-cycle pulse when Plain_Out is valid
//   Plain_Out  recovered plain text, held until the next Done
module aes128_inv_cipher_iter #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_CACHE  = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [127:0] Key_In,
  input  logic [127:0] Cipher_In,
  output logic         Busy,
  output logic         Done,
  output logic [127:0] Plain_Out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXPAND = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (9, b, d, e)
  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00)
         ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {
      gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
      gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
      gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
      gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
    };
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [2:0]   st;
  logic [3:0]   cnt;
  logic [127:0] state_r;
  logic [127:0] wkey;
  logic [127:0] key_l;
  logic [127:0] ck_key;
  logic [127:0] ck_rk;
  logic         ck_vld;

  // state datapath
  logic [0:15][7:0] st_b;
  logic [0:15][7:0] isr;
  logic [0:15][7:0] isb;
  logic [127:0]     ark;
  logic [127:0]     mix;

  assign st_b = state_r;

  assign isr = {
    st_b[0],  st_b[13], st_b[10], st_b[7],
    st_b[4],  st_b[1],  st_b[14], st_b[11],
    st_b[8],  st_b[5],  st_b[2],  st_b[15],
    st_b[12], st_b[9],  st_b[6],  st_b[3]
  };

  genvar g;
  for (g = 0; g < 16; g++) begin : g_isb
    assign isb[g] = ISBOX[isr[g]];
  end

  assign ark = isb ^ wkey;

  for (g = 0; g < 4; g++) begin : g_mix
    assign mix[127-32*g -: 32] =
      inv_mix_col(ark[127-32*g -: 32]);
  end

  // key schedule; one SubWord shared by both directions
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, rot, sub_out, t;
  logic [3:0]   ridx;
  logic [127:0] fwd_key, inv_key;
  logic [31:0]  n0, n1, n2;

  assign {w0, w1, w2, w3} = wkey;

  // backwards, the word fed to SubWord is w[j-1] = w3 ^ w2
  assign sub_in = (st == S_EXPAND) ? w3 : (w3 ^ w2);
  assign rot    = {sub_in[23:0], sub_in[31:24]};
  assign sub_out = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                    SBOX[rot[15:8]],  SBOX[rot[7:0]]};
  assign ridx = (st == S_INIT) ? 4'(NUM_ROUNDS) : cnt;
  assign t    = sub_out ^ {rcon(ridx), 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign fwd_key = {n0, n1, n2, w3 ^ n2};
  assign inv_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st        <= S_IDLE;
      cnt       <= '0;
      state_r   <= '0;
      wkey      <= '0;
      key_l     <= '0;
      ck_key    <= '0;
      ck_rk     <= '0;
      ck_vld    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Plain_Out <= '0;
    end else begin
      Done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (Start) begin
            state_r <= Cipher_In;
            key_l   <= Key_In;
            Busy    <= 1'b1;
            if (KEY_CACHE != 0 && ck_vld &&
                Key_In == ck_key) begin
              wkey <= ck_rk;
              st   <= S_INIT;
            end else begin
              wkey <= Key_In;
              cnt  <= 4'd1;
              st   <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          wkey <= fwd_key;
          if (cnt == 4'(NUM_ROUNDS)) begin
            st <= S_INIT;
            if (KEY_CACHE != 0) begin
              ck_rk  <= fwd_key;
              ck_key <= key_l;
              ck_vld <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_INIT: begin
          state_r <= state_r ^ wkey;
          wkey    <= inv_key;
          cnt     <= 4'(NUM_ROUNDS - 1);
          st      <= S_ROUND;
        end
        S_ROUND: begin
          state_r <= mix;
          wkey    <= inv_key;
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd1) st <= S_FINAL;
        end
        S_FINAL: begin
          Plain_Out <= isb ^ wkey;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          st        <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Scoreboard bench for aes128_inv_cipher_iter.
// Directed FIPS-197 vectors plus a loopback through an encrypt model.
module tb_aes128_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [127:0] Key_In;
  logic [127:0] Cipher_In;
  logic         Busy;
  logic         Done;
  logic [127:0] Plain_Out;

  aes128_inv_cipher_iter dut (
    .Clk       (clk),
    .Rst       (Rst),
    .Start     (Start),
    .Key_In    (Key_In),
    .Cipher_In (Cipher_In),
    .Busy      (Busy),
    .Done      (Done),
    .Plain_Out (Plain_Out)
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KT = 128'h00004453454320564C53492050726F6A;
  localparam logic [127:0] PT = 128'h00004453454320123456789012345678;

  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // forward cipher, stands in for the encrypt path
  function automatic logic [127:0] aes_enc(
    input logic [127:0] pt,
    input logic [127:0] key
  );
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32*i));
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {SB[tmp[23:16]], SB[tmp[15:8]],
               SB[tmp[7:0]],   SB[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++)
      s[b] = 8'(pt >> (120 - 8*b)) ^ 8'(w[b/4] >> (24 - 8*(b%4)));
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++)
        t[b] = SB[s[4*(((b/4) + (b%4)) % 4) + (b%4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        for (int b = 0; b < 16; b++) s[b] = t[b];
      end
      for (int b = 0; b < 16; b++)
        s[b] = s[b] ^ 8'(w[4*r + b/4] >> (24 - 8*(b%4)));
    end
    o = '0;
    for (int b = 0; b < 16; b++) o = {o[119:0], s[b]};
    return o;
  endfunction

  typedef struct {
    logic [127:0] pt;
    int           e0;
    int           lat;
  } exp_t;

  exp_t q [$];
  exp_t me;

  // monitor: every Done pops one expectation
  always @(negedge clk) begin
    if (Done) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done cyc=%0d got Done=1 want none",
                 cyc);
      end else begin
        me = q.pop_front();
        nvec++;
        if (Plain_Out !== me.pt) begin
          nerr++;
          $display("FAIL plain_out got %h want %h", Plain_Out, me.pt);
        end
        nvec++;
        if (cyc - me.e0 != me.lat) begin
          nerr++;
          $display("FAIL latency got %0d want %0d",
                   cyc - me.e0, me.lat);
        end
      end
    end
  end

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc != target && k < 200) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (cyc != target) begin
      nerr++;
      $display("FAIL sync got cyc %0d want %0d", cyc, target);
    end
  endtask

  task automatic run(input logic [127:0] k,
                     input logic [127:0] c,
                     input logic [127:0] p,
                     input int lat);
    @(negedge clk);
    Key_In    = k;
    Cipher_In = c;
    Start     = 1'b1;
    q.push_back('{p, cyc + 1, lat});
    @(negedge clk);
    Start     = 1'b0;
    Key_In    = ~k;
    Cipher_In = ~c;
    wait_drain(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e;
    Rst       = 1'b1;
    Start     = 1'b0;
    Key_In    = '0;
    Cipher_In = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(Busy), 128'd0);
    check("rst_done", 128'(Done), 128'd0);
    check("rst_plain", Plain_Out, 128'd0);
    Rst = 1'b0;

    check("enc_model_c1", aes_enc(P1, K1), C1);

    run(K1, C1, P1, 21);
    run(KB, CB, PB, 21);
    run(KB, CB, PB, 11);
    run(K1, C1, P1, 21);

    // Start held high over three uncached blocks
    @(negedge clk);
    Key_In    = KB;
    Cipher_In = CB;
    Start     = 1'b1;
    e = cyc + 1;
    q.push_back('{PB, e, 21});
    wait_cyc(e + 21);
    Key_In    = K1;
    Cipher_In = C1;
    q.push_back('{P1, e + 22, 21});
    wait_cyc(e + 43);
    Key_In    = KB;
    Cipher_In = CB;
    q.push_back('{PB, e + 44, 21});
    wait_cyc(e + 65);
    Start = 1'b0;
    wait_drain(20);

    // reset in the middle of expansion
    @(negedge clk);
    Key_In    = KB;
    Cipher_In = CB;
    Start     = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    Start = 1'b0;
    wait_cyc(e + 6);
    Rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 128'(Busy), 128'd0);
    check("abort_done", 128'(Done), 128'd0);
    check("abort_plain", Plain_Out, 128'd0);
    Rst = 1'b0;

    run(KB, CB, PB, 21);
    run(K1, C1, P1, 21);
    run(KT, aes_enc(PT, KT), PT, 21);

    repeat (3) @(negedge clk);
    check("hold_plain", Plain_Out, PT);
    check("idle_busy", 128'(Busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
